spi_slave_rx_mq: RTL and testbench
==================================

SPI_SLAVE_RX_MQ -- requirements
Module: spi_slave_rx_mq

Interface
REQ-001 The block SHALL have parameters: DATA_WIDTH, default 32, word width in bits, multiple of 4 and at least 8; FIFO_DEPTH, default 4, number of received words buffered, power of 2 and at least 2; CNT_WIDTH, default 8, width of the shift-count fields.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset. The ports, clock and reset first, SHALL be:
- sclk  in  1  SPI clock, the only clock.
- cs  in  1  synchronous active-high reset, sampled on posedge sclk; high means the slave is deselected.
- sdi  in  4  serial data lanes; lane 0 is used in single mode.
- mode  in  2  lane mode: 00 single, 01 dual (sdi[1:0]), 10 quad, 11 treated as single.
- counter_in  in  CNT_WIDTH  shift cycles minus 1 for the next word.
- counter_in_upd  in  1  one-cycle strobe that loads counter_in and starts a word.
- cont  in  1  when 1, a completed word restarts automatically with the same target.
- data  out  DATA_WIDTH  head-of-FIFO word.
- data_valid  out  1  FIFO is not empty.
- data_ready  in  1  consumer accepts data; a pop occurs when data_valid and data_ready are both 1.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky flag: a word was dropped.
- busy  out  1  a word is being shifted in.

Function
REQ-003 The FSM SHALL have three states: CMD, RUN and HOLD.
REQ-004 CMD SHALL be entered on reset; the target is 7; one bit per cycle is taken from sdi[0] regardless of mode.
REQ-005 RUN SHALL shift in 1, 2 or 4 bits per cycle according to mode, using the target loaded by counter_in_upd.
REQ-006 In CMD or RUN, each cycle SHALL do shift <= {shift[DATA_WIDTH-1-k:0], new bits}, with k = bits per cycle; bits shifted out of the top SHALL be discarded; sdi[k-1] SHALL be the MSB of the new bits.
REQ-007 The counter SHALL increment each shifting cycle; when counter == target, the word SHALL be complete: the value including this cycle's bits is pushed and the counter clears to 0.
REQ-008 On completion, the next state SHALL be: RUN if counter_in_upd is 1 (new target); otherwise RUN with the unchanged target if cont is 1; otherwise HOLD.
REQ-009 counter_in_upd in any state SHALL load the target, clear the counter and shift register, and enter RUN on the next cycle; if the strobe arrives mid-word, the partial word SHALL be discarded without a push.
REQ-010 HOLD SHALL shift nothing and SHALL leave HOLD only on counter_in_upd.
REQ-011 The word pushed at edge N SHALL be visible on data with data_valid=1 after edge N (one cycle of latency); the FIFO is show-ahead.
REQ-012 Push and pop in the same cycle SHALL both take effect and leave level unchanged, including when the FIFO is full or empty with a push.
REQ-013 A push when full without a simultaneous pop SHALL drop the new word, set overflow and leave the FIFO unchanged.
REQ-014 The read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range from 0 to FIFO_DEPTH.
REQ-015 busy SHALL be 1 in CMD and RUN, and 0 in HOLD.
REQ-016 When counter_in is 0, RUN SHALL complete a word every cycle.

Reset
REQ-017 While cs=1 at a posedge of sclk, the block SHALL enter CMD and set: counter=0, target=7, shift=0, FIFO empty, level=0, data_valid=0, data=0, overflow=0, busy=1.
REQ-018 cs asserted mid-word or with the FIFO non-empty SHALL discard all contents with no partial push; overflow SHALL clear only on reset.

Configuration
REQ-019 With SPI_SLAVE_RX_LSB_FIRST_EN defined, the block SHALL have an extra input port lsb_first (1 bit); when it is 1, each word SHALL be bit-reversed over the low (target+1)*k bits before the push.
REQ-020 Without SPI_SLAVE_RX_LSB_FIRST_EN, the lsb_first port SHALL be absent and words SHALL be MSB first only.

Structure
REQ-021 Package spi_slave_pkg SHALL hold: the lane-mode enum (SINGLE, DUAL, QUAD), the FSM state enum, and the CMD_TARGET=7 constant.
REQ-022 The FIFO SHALL be the sub-module spi_slave_rx_fifo, parametrised by width and depth, with push/pop/full/empty/level and a synchronous active-high reset.

Verification
REQ-023 Reset release, sdi[0] serial 0xA5 over 8 cycles -> one push, data=0x000000A5, data_valid=1 one cycle after the 8th edge, state HOLD.
REQ-024 counter_in=7 with upd, quad mode, nibbles 1..8 -> data=0x12345678 pushed, busy=0 afterwards.
REQ-025 Dual mode, cont=1, counter_in=15, data_ready=0, 5 words -> level reaches 4, 5th word dropped, overflow=1, the first 4 words are intact in order.
REQ-026 FIFO full with push and pop in the same cycle -> level stays 4, the oldest word is popped, the new word is at the tail, overflow unchanged.
REQ-027 cs=1 asserted mid-word with level=2 -> next cycle level=0, data_valid=0, overflow=0, CMD state with target 7.
REQ-028 With the macro defined: lsb_first=1, single mode, counter_in=7, bits 1,0,0,0,0,0,0,0 -> data=0x01; without the macro -> data=0x80.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
// Shared types and constants for the SPI slave receiver.
//   lane_mode_e      : value of the 2-bit mode input (11 behaves as SINGLE)
//   rx_state_e       : receiver FSM states (CMD, RUN, HOLD)
//   CMD_TARGET       : shift-count target used in CMD (8 single-lane bits)
//   lanes_per_cycle(): number of new bits taken per sclk cycle
// ---------------------------------------------------------------------------
package spi_slave_pkg;

   typedef enum logic [1:0] {
      SINGLE = 2'b00,
      DUAL   = 2'b01,
      QUAD   = 2'b10
   } lane_mode_e;

   typedef enum logic [1:0] {
      CMD  = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10
   } rx_state_e;

   localparam int CMD_TARGET = 7;

   // CMD always samples one lane; only RUN honours the lane mode.
   function automatic logic [2:0] lanes_per_cycle(input rx_state_e st, input logic [1:0] mode);
      logic [2:0] n;
      n = 3'd1;
      if (st == RUN) begin
         if (mode == DUAL) begin
            n = 3'd2;
         end else if (mode == QUAD) begin
            n = 3'd4;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_fifo
// Show-ahead FIFO for received words. The head word is presented on
// pop_data as soon as it is written; pop_data is forced to 0 when empty.
// Ports:
//   clk, srst           : clock, synchronous active-high reset
//   push, push_data     : write request and word (ignored when full unless
//                         a pop happens in the same cycle)
//   pop                 : read request (ignored when empty)
//   pop_data            : head-of-FIFO word
//   full, empty, level  : occupancy status, level in 0..DEPTH
// ---------------------------------------------------------------------------
module spi_slave_rx_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_reg == LW'(DEPTH));
   assign empty   = (level_reg == '0);
   assign do_pop  = pop && !empty;
   // When full, a simultaneous pop frees the slot the write lands in.
   assign do_push = push && (!full || do_pop);

   assign pop_data = empty ? '0 : mem[rd_ptr_reg];
   assign level    = level_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/spi_slave_rx_mq.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_mq
// SPI slave receiver with 1/2/4-lane shifting and a show-ahead word FIFO.
// After reset the block sits in CMD and collects an 8-bit command on
// sdi[0]; counter_in_upd then starts RUN words of (counter_in+1) cycles.
// Ports:
//   sclk            : the only clock
//   cs              : synchronous active-high reset (high = deselected)
//   sdi[3:0]        : serial lanes, sdi[k-1] is the MSB of each beat
//   mode[1:0]       : 00 single, 01 dual, 10 quad, 11 single
//   counter_in      : shift cycles minus 1 for the next word
//   counter_in_upd  : strobe loading counter_in and starting a word
//   cont            : restart automatically after a completed word
//   data, data_valid, data_ready : FIFO head handshake
//   level           : FIFO occupancy
//   overflow        : sticky, a word was dropped on a full FIFO
//   busy            : 1 in CMD and RUN
//   lsb_first       : only with SPI_SLAVE_RX_LSB_FIRST_EN defined; reverses
//                     the received bits of each word before the push
// ---------------------------------------------------------------------------
module spi_slave_rx_mq #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                          sclk,
   input  logic                          cs,
   input  logic [3:0]                    sdi,
   input  logic [1:0]                    mode,
   input  logic [CNT_WIDTH-1:0]          counter_in,
   input  logic                          counter_in_upd,
   input  logic                          cont,
   output logic [DATA_WIDTH-1:0]         data,
   output logic                          data_valid,
   input  logic                          data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          busy
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
   ,
   input  logic                          lsb_first
`endif
);

   import spi_slave_pkg::*;

   rx_state_e              state_reg;
   logic [CNT_WIDTH-1:0]   target_reg;
   logic [CNT_WIDTH-1:0]   count_reg;
   logic [DATA_WIDTH-1:0]  shift_reg;
   logic                   overflow_reg;

   logic [2:0]             lanes;
   logic [DATA_WIDTH-1:0]  shift_next;
   logic [DATA_WIDTH-1:0]  push_word;
   logic                   shifting;
   logic                   word_done;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;

   assign lanes     = lanes_per_cycle(state_reg, mode);
   assign shifting  = (state_reg != HOLD);
   assign word_done = (count_reg == target_reg);
   // A word completing in the same cycle as a strobe is still pushed;
   // only an unfinished word is thrown away by the strobe.
   assign push      = shifting && word_done;
   assign pop       = data_valid && data_ready;

   // New bits enter at the bottom; bits leaving the top are lost.
   always_comb begin
      shift_next = {shift_reg[DATA_WIDTH-2:0], sdi[0]};
      if (lanes == 3'd2) begin
         shift_next = {shift_reg[DATA_WIDTH-3:0], sdi[1:0]};
      end else if (lanes == 3'd4) begin
         shift_next = {shift_reg[DATA_WIDTH-5:0], sdi};
      end
   end

`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
   logic [DATA_WIDTH-1:0]  rev_full;
   logic [DATA_WIDTH-1:0]  low_mask;
   int unsigned            word_len;

   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
      assign rev_full[gi] = shift_next[DATA_WIDTH-1-gi];
   end

   // Reversing only the received span: full reversal, then shift the
   // span back down to bit 0; bits above the span pass unchanged.
   always_comb begin
      word_len = (32'(target_reg) + 32'd1) * 32'(lanes);
      if (word_len > 32'(DATA_WIDTH)) begin
         word_len = 32'(DATA_WIDTH);
      end
      low_mask  = ~({DATA_WIDTH{1'b1}} << word_len);
      push_word = shift_next;
      if (lsb_first) begin
         push_word = (shift_next & ~low_mask)
                   | ((rev_full >> (32'(DATA_WIDTH) - word_len)) & low_mask);
      end
   end
`else
   assign push_word = shift_next;
`endif

   always_ff @(posedge sclk) begin
      if (cs) begin
         state_reg    <= CMD;
         target_reg   <= CNT_WIDTH'(CMD_TARGET);
         count_reg    <= '0;
         shift_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
         end
         if (counter_in_upd) begin
            state_reg  <= RUN;
            target_reg <= counter_in;
            count_reg  <= '0;
            shift_reg  <= '0;
         end else if (shifting) begin
            shift_reg <= shift_next;
            if (word_done) begin
               count_reg <= '0;
               state_reg <= cont ? RUN : HOLD;
            end else begin
               count_reg <= count_reg + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign overflow = overflow_reg;
   assign busy     = (state_reg != HOLD);

   spi_slave_rx_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (sclk),
      .srst      (cs),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .pop_data  (data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   assign data_valid = !fifo_empty;

endmodule

// File: tb/tb_spi_slave_rx_mq.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx_mq
// Self-checking bench for spi_slave_rx_mq (default parameters). Directed
// scenarios compare against hand-derived constants; a randomized run
// compares every cycle against a word-level reference model (queue FIFO).
// Inputs change #1 after posedge sclk and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx_mq;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 8;

   logic          sclk = 1'b0;
   logic          cs = 1'b1;
   logic [3:0]    sdi = '0;
   logic [1:0]    mode = '0;
   logic [CW-1:0] counter_in = '0;
   logic          counter_in_upd = 1'b0;
   logic          cont = 1'b0;
   logic [DW-1:0] data;
   logic          data_valid;
   logic          data_ready = 1'b0;
   logic [2:0]    level;
   logic          overflow;
   logic          busy;
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
   logic          lsb_first = 1'b0;
`endif

   int vectors = 0;
   int miscompares = 0;

   // reference model: phase 0 = collecting command, 1 = running, 2 = idle
   int            m_phase;
   int            m_target;
   int            m_count;
   logic [DW-1:0] m_acc;
   logic [DW-1:0] m_q[$];
   bit            m_ovf;

   logic [DW-1:0] words [6];

   spi_slave_rx_mq #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .sclk           (sclk),
      .cs             (cs),
      .sdi            (sdi),
      .mode           (mode),
      .counter_in     (counter_in),
      .counter_in_upd (counter_in_upd),
      .cont           (cont),
      .data           (data),
      .data_valid     (data_valid),
      .data_ready     (data_ready),
      .level          (level),
      .overflow       (overflow),
      .busy           (busy)
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
      ,
      .lsb_first      (lsb_first)
`endif
   );

   always #5 sclk = ~sclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got=running exp=finished");
      $fatal(1, "watchdog");
   end

   // One clock of the reference: word assembly from the bit stream plus a
   // bounded queue, evaluated with the inputs present before the edge.
   task automatic model_update();
      int k;
      int n;
      bit popd;
      bit pushd;
      logic [DW-1:0] w;
      if (cs) begin
         m_phase = 0; m_target = 7; m_count = 0; m_acc = '0; m_ovf = 0;
         m_q.delete();
         return;
      end
      k = 1;
      if (m_phase == 1) k = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
      popd  = (m_q.size() != 0) && data_ready;
      pushd = 0;
      w     = '0;
      if (m_phase != 2) begin
         m_acc = (m_acc << k) | (DW'(sdi) & ((DW'(1) << k) - DW'(1)));
         if (m_count == m_target) begin
            pushd = 1;
            w = m_acc;
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
            if (lsb_first) begin
               n = (m_target + 1) * k;
               if (n > DW) n = DW;
               for (int i = 0; i < n; i++) w[i] = m_acc[n-1-i];
            end
`endif
            m_count = 0;
            m_phase = cont ? 1 : 2;
         end else begin
            m_count++;
         end
      end
      if (counter_in_upd) begin
         m_target = int'(counter_in); m_count = 0; m_acc = '0; m_phase = 1;
      end
      if (pushd && m_q.size() == DEPTH && !popd) begin
         m_ovf = 1;
      end else begin
         if (popd) void'(m_q.pop_front());
         if (pushd) m_q.push_back(w);
      end
      n = 0;
   endtask

   task automatic step();
      model_update();
      @(posedge sclk);
      #1;
   endtask

   task automatic test_reset();
      cs = 1'b1; sdi = 4'hF; counter_in_upd = 1'b0; data_ready = 1'b1;
      step(); step();
      data_ready = 1'b0;
      vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL rst_level got=%0d exp=0", level); end
      vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
      vectors++; if (data !== 32'h0) begin miscompares++; $display("FAIL rst_data got=%h exp=00000000", data); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy got=%b exp=1", busy); end
      $display("test_reset: level=%0d valid=%b busy=%b", level, data_valid, busy);
   endtask

   // Command phase: single lane regardless of mode, eight bits, then idle.
   task automatic test_cmd();
      logic [7:0] cmd;
      cmd = 8'hA5;
      cs = 1'b0; mode = 2'b10; cont = 1'b0;
      for (int b = 7; b >= 0; b--) begin
         sdi = {3'($urandom_range(0, 7)), cmd[b]};
         step();
         if (b == 1) begin
            vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL cmd_early_valid got=%b exp=0", data_valid); end
         end
      end
      vectors++; if (data_valid !== 1'b1) begin miscompares++; $display("FAIL cmd_valid got=%b exp=1", data_valid); end
      vectors++; if (data !== 32'h000000A5) begin miscompares++; $display("FAIL cmd_data got=%h exp=000000a5", data); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cmd_busy got=%b exp=0", busy); end
      for (int i = 0; i < 5; i++) begin sdi = 4'($urandom); step(); end
      vectors++; if (level !== 3'd1) begin miscompares++; $display("FAIL cmd_hold_level got=%0d exp=1", level); end
      data_ready = 1'b1; step(); data_ready = 1'b0;
      vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL cmd_pop_level got=%0d exp=0", level); end
      $display("test_cmd: word=000000a5 popped");
   endtask

   task automatic test_quad();
      mode = 2'b10; counter_in = 8'd7; counter_in_upd = 1'b1; sdi = 4'h0;
      step();
      counter_in_upd = 1'b0;
      for (int n = 1; n <= 8; n++) begin sdi = 4'(n); step(); end
      vectors++; if (data !== 32'h12345678) begin miscompares++; $display("FAIL quad_data got=%h exp=12345678", data); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL quad_busy got=%b exp=0", busy); end
      data_ready = 1'b1; step(); data_ready = 1'b0;
      $display("test_quad: word=12345678");
   endtask

   task automatic send_dual(input logic [DW-1:0] w, input int beats);
      for (int b = 0; b < beats; b++) begin
         sdi = {2'b00, w[31-2*b -: 2]};
         step();
      end
   endtask

   task automatic test_overflow();
      mode = 2'b01; cont = 1'b1; data_ready = 1'b0;
      counter_in = 8'd15; counter_in_upd = 1'b1; sdi = 4'h0;
      step();
      counter_in_upd = 1'b0;
      for (int w = 0; w < 5; w++) begin
         words[w] = $urandom;
         send_dual(words[w], 16);
         if (w == 3) begin
            vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL ovf_level4 got=%0d exp=4", level); end
            vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got=%b exp=0", overflow); end
         end
      end
      vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL ovf_level got=%0d exp=4", level); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      vectors++; if (data !== words[0]) begin miscompares++; $display("FAIL ovf_head got=%h exp=%h", data, words[0]); end
      $display("test_overflow: dropped=%h", words[4]);
   endtask

   task automatic test_full_push_pop();
      logic [DW-1:0] exp_order [4];
      words[5] = $urandom;
      send_dual(words[5], 15);
      data_ready = 1'b1; cont = 1'b0;
      send_dual(words[5] << 30, 1);
      data_ready = 1'b0;
      vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL pp_level got=%0d exp=4", level); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL pp_ovf got=%b exp=1", overflow); end
      exp_order[0] = words[1]; exp_order[1] = words[2];
      exp_order[2] = words[3]; exp_order[3] = words[5];
      data_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (data !== exp_order[i]) begin miscompares++; $display("FAIL pp_drain%0d got=%h exp=%h", i, data, exp_order[i]); end
         step();
      end
      data_ready = 1'b0;
      vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL pp_empty got=%0d exp=0", level); end
      $display("test_full_push_pop: tail=%h", words[5]);
   endtask

   task automatic test_cs_midword();
      logic [7:0] cmd;
      mode = 2'b00; cont = 1'b1; counter_in = 8'd7; counter_in_upd = 1'b1;
      step();
      counter_in_upd = 1'b0;
      for (int i = 0; i < 19; i++) begin sdi = 4'($urandom); step(); end
      vectors++; if (level !== 3'd2) begin miscompares++; $display("FAIL cs_pre_level got=%0d exp=2", level); end
      cs = 1'b1; step(); cs = 1'b0;
      vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL cs_level got=%0d exp=0", level); end
      vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL cs_valid got=%b exp=0", data_valid); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL cs_ovf got=%b exp=0", overflow); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cs_busy got=%b exp=1", busy); end
      cmd = 8'h3C; cont = 1'b0; mode = 2'b01;
      for (int b = 7; b >= 0; b--) begin
         sdi = {3'b000, cmd[b]};
         step();
         if (b == 1) begin
            vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL cs_cmd_early got=%b exp=0", data_valid); end
         end
      end
      vectors++; if (data !== 32'h0000003C) begin miscompares++; $display("FAIL cs_cmd_data got=%h exp=0000003c", data); end
      data_ready = 1'b1; step(); data_ready = 1'b0;
      $display("test_cs_midword: cmd word=0000003c");
   endtask

   task automatic test_lsb_first();
      logic [DW-1:0] expv;
      mode = 2'b00; cont = 1'b0; counter_in = 8'd7; counter_in_upd = 1'b1;
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
      lsb_first = 1'b1;
      expv = 32'h01;
`else
      expv = 32'h80;
`endif
      step();
      counter_in_upd = 1'b0;
      for (int b = 0; b < 8; b++) begin sdi = (b == 0) ? 4'h1 : 4'h0; step(); end
      vectors++; if (data !== expv) begin miscompares++; $display("FAIL lsb_data got=%h exp=%h", data, expv); end
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
      lsb_first = 1'b0;
`endif
      data_ready = 1'b1; step(); data_ready = 1'b0;
      $display("test_lsb_first: word=%h", expv);
   endtask

   task automatic test_random();
      logic [DW-1:0] exp_data;
      int pops;
      pops = 0;
      cs = 1'b1; counter_in_upd = 1'b0; step(); cs = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         cs             = ($urandom_range(0, 299) == 0);
         counter_in_upd = ($urandom_range(0, 19) == 0);
         counter_in     = CW'($urandom_range(0, 20));
         mode           = 2'($urandom);
         cont           = 1'($urandom);
         data_ready     = ($urandom_range(0, 2) == 0);
         sdi            = 4'($urandom);
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
         lsb_first      = 1'($urandom);
`endif
         if (data_valid && data_ready && !cs) pops++;
         step();
         exp_data = (m_q.size() != 0) ? m_q[0] : '0;
         vectors++; if (level !== 3'(m_q.size())) begin miscompares++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", c, level, m_q.size()); end
         vectors++; if (data_valid !== (m_q.size() != 0)) begin miscompares++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, data_valid, m_q.size() != 0); end
         vectors++; if (data !== exp_data) begin miscompares++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, data, exp_data); end
         vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, overflow, m_ovf); end
         vectors++; if (busy !== (m_phase != 2)) begin miscompares++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, m_phase != 2); end
      end
      cs = 1'b0; counter_in_upd = 1'b0; data_ready = 1'b0;
      $display("test_random: 3000 cycles, %0d pops", pops);
   endtask

   initial begin
      test_reset();
      test_cmd();
      test_quad();
      test_overflow();
      test_full_push_pop();
      test_cs_midword();
      test_lsb_first();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
